// File: rtl/key_reset_conditioner.sv
// Board push-button conditioner: per-key synchroniser and debouncer with level/press outputs,
// plus a stretched, clock-aligned active-high reset driven by board reset or KEY[0].
module key_reset_conditioner #(
  parameter int KEY_W           = 2,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int RST_HOLD_CYCLES = 16
) (
  input  logic             ss_clk_in,
  input  logic             ss_reset_in,
  input  logic [KEY_W-1:0] key_in,
  output logic [KEY_W-1:0] key_level_o,
  output logic [KEY_W-1:0] key_press_o,
  output logic             sys_reset_o,
  output logic [1:0]       rst_state_o
);

  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;

  localparam logic [CNT_W-1:0]  DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);

  localparam logic [1:0] ST_ASSERT   = 2'd0;
  localparam logic [1:0] ST_HOLD     = 2'd1;
  localparam logic [1:0] ST_RUN      = 2'd2;
  localparam logic [1:0] ST_WAIT_REL = 2'd3;

  logic [KEY_W-1:0] sync_q [SYNC_STAGES];
  logic [KEY_W-1:0] key_s;

  // NOTE: every clocked block uses non-blocking assignments so all flops update from
  // pre-edge values; blocking here would collapse the synchroniser chain into one stage.
  // NOTE: these arrays are a handful of flops, not RAM, so resetting them costs nothing
  // and guarantees a released (all-ones) key view right after reset.
  always_ff @(posedge ss_clk_in or negedge ss_reset_in) begin
    if (!ss_reset_in) begin
      for (int j = 0; j < SYNC_STAGES; j++) sync_q[j] <= '1;
    end else begin
      sync_q[0] <= key_in;
      for (int j = 1; j < SYNC_STAGES; j++) sync_q[j] <= sync_q[j-1];
    end
  end

  // Keys are active-low at the pin; internally 1 means pressed.
  assign key_s = ~sync_q[SYNC_STAGES-1];

  logic [CNT_W-1:0] db_cnt_q [KEY_W];
  logic [KEY_W-1:0] db_done;

  always_comb begin
    for (int i = 0; i < KEY_W; i++) begin
      db_done[i] = (key_s[i] != key_level_o[i]) && (db_cnt_q[i] == DB_LAST);
    end
  end

  // The counter clears on any agreement with the accepted level, so only an unbroken
  // run of DEBOUNCE_CYCLES disagreeing samples can flip the level.
  always_ff @(posedge ss_clk_in or negedge ss_reset_in) begin
    if (!ss_reset_in) begin
      for (int i = 0; i < KEY_W; i++) db_cnt_q[i] <= '0;
      key_level_o <= '0;
      key_press_o <= '0;
    end else begin
      for (int i = 0; i < KEY_W; i++) begin
        if ((key_s[i] == key_level_o[i]) || db_done[i]) db_cnt_q[i] <= '0;
        else                                             db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
      end
      key_level_o <= key_level_o ^ db_done;
      key_press_o <= db_done & key_s;
    end
  end

  logic [1:0]        state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  // NOTE: defaults first so every path assigns both outputs; a missing branch would infer a latch.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      ST_ASSERT: begin
        state_d = ST_HOLD;
        hold_d  = '0;
      end
      ST_HOLD: begin
        // A fresh KEY[0] press outranks hold completion in the same cycle.
        if (key_level_o[0])          state_d = ST_WAIT_REL;
        else if (hold_q == HOLD_LAST) state_d = ST_RUN;
        else                          hold_d  = hold_q + 1'b1;
      end
      ST_RUN: begin
        if (key_level_o[0]) state_d = ST_WAIT_REL;
      end
      ST_WAIT_REL: begin
        if (!key_level_o[0]) begin
          state_d = ST_HOLD;
          hold_d  = '0;
        end
      end
      default: state_d = ST_ASSERT;
    endcase
  end

  // sys_reset_o is registered so its deassertion is a clean flop edge, not a state decode.
  always_ff @(posedge ss_clk_in or negedge ss_reset_in) begin
    if (!ss_reset_in) begin
      state_q     <= ST_ASSERT;
      hold_q      <= '0;
      sys_reset_o <= 1'b1;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      sys_reset_o <= (state_d != ST_RUN);
    end
  end

  assign rst_state_o = state_q;

endmodule

// File: tb/tb_key_reset_conditioner.sv
// Self-checking bench for key_reset_conditioner: directed vector table, randomized keys
// against a window-based reference model, and hand sequences for hold priority and async reset.
module tb_key_reset_conditioner;

  localparam int SYNC = 2;
  localparam int DB   = 8;
  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] key_in;
  logic [1:0] key_level, key_press;
  logic       sys_reset;
  logic [1:0] rst_state;

  // Second instance with a short debounce and long hold so a KEY[0] press can land
  // exactly in the final HOLD cycle.
  logic [1:0] key2;
  logic [1:0] level2, press2;
  logic       sys2;
  logic [1:0] state2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  key_reset_conditioner #(
    .KEY_W(2), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DB), .RST_HOLD_CYCLES(HOLD)
  ) u_dut (
    .ss_clk_in(clk), .ss_reset_in(rst_n), .key_in(key_in),
    .key_level_o(key_level), .key_press_o(key_press),
    .sys_reset_o(sys_reset), .rst_state_o(rst_state)
  );

  key_reset_conditioner #(
    .KEY_W(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(2), .RST_HOLD_CYCLES(8)
  ) u_dut2 (
    .ss_clk_in(clk), .ss_reset_in(rst_n), .key_in(key2),
    .key_level_o(level2), .key_press_o(press2),
    .sys_reset_o(sys2), .rst_state_o(state2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a key's level flips when the last DB synchronised samples all
  // disagree with it; the reset output follows a count of consecutive "quiet" edges.
  logic [1:0] kq[$];
  logic [1:0] m_level, m_press;
  int         m_quiet;
  bit         m_started;

  task automatic model_reset();
    m_level   = '0;
    m_press   = '0;
    m_quiet   = 0;
    m_started = 0;
    kq.delete();
    for (int n = 0; n < SYNC + DB; n++) kq.push_back(2'b11);
  endtask

  task automatic model_edge(input logic [1:0] k);
    logic [1:0] new_level;
    logic [1:0] raw;
    logic       old_l0;
    bit         all_diff;
    old_l0 = m_level[0];
    kq.push_back(k);
    for (int i = 0; i < 2; i++) begin
      all_diff = 1;
      for (int w = 0; w < DB; w++) begin
        raw = kq[kq.size() - 1 - SYNC - w];
        if (!raw[i] == m_level[i]) all_diff = 0;
      end
      new_level[i] = all_diff ? !m_level[i] : m_level[i];
    end
    m_press = new_level & ~m_level;
    m_level = new_level;
    // First edge out of reset always starts the hold; after that any edge seeing
    // KEY[0] pressed breaks the quiet run.
    if (!m_started) begin
      m_started = 1;
      m_quiet   = 1;
    end else if (old_l0) begin
      m_quiet = 0;
    end else if (m_quiet <= HOLD) begin
      m_quiet++;
    end
    void'(kq.pop_front());
  endtask

  function automatic logic exp_sys();
    return !(m_quiet > HOLD);
  endfunction

  function automatic logic [1:0] exp_state();
    if (!m_started)    return 2'd0;
    if (m_quiet == 0)  return 2'd3;
    if (m_quiet > HOLD) return 2'd2;
    return 2'd1;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge(key_in);
    #2;
    check("model_level", key_level, m_level);
    check("model_press", key_press, m_press);
    check("model_sys_reset", sys_reset, exp_sys());
    check("model_state", rst_state, exp_state());
  endtask

  typedef struct {
    logic [1:0] keys;
    int         cycles;
    logic [1:0] level;
    logic [1:0] press;
    logic       sys;
    logic [1:0] state;
  } vec_t;

  vec_t vecs[17];

  initial begin
    vecs[0]  = '{2'b11, 1,  2'b00, 2'b00, 1'b1, 2'd1};  // ASSERT -> HOLD
    vecs[1]  = '{2'b11, 3,  2'b00, 2'b00, 1'b1, 2'd1};
    vecs[2]  = '{2'b11, 1,  2'b00, 2'b00, 1'b0, 2'd2};  // 1 ASSERT + 4 HOLD, then RUN
    vecs[3]  = '{2'b01, 9,  2'b00, 2'b00, 1'b0, 2'd2};  // key1 pressed, not yet accepted
    vecs[4]  = '{2'b01, 1,  2'b10, 2'b10, 1'b0, 2'd2};  // accepted after 10 clocks, pulse
    vecs[5]  = '{2'b01, 1,  2'b10, 2'b00, 1'b0, 2'd2};  // pulse lasts one cycle
    vecs[6]  = '{2'b11, 9,  2'b10, 2'b00, 1'b0, 2'd2};
    vecs[7]  = '{2'b11, 1,  2'b00, 2'b00, 1'b0, 2'd2};  // release, no pulse
    vecs[8]  = '{2'b01, 5,  2'b00, 2'b00, 1'b0, 2'd2};  // short glitch
    vecs[9]  = '{2'b11, 12, 2'b00, 2'b00, 1'b0, 2'd2};  // glitch rejected
    vecs[10] = '{2'b10, 10, 2'b01, 2'b01, 1'b0, 2'd2};  // KEY[0] accepted
    vecs[11] = '{2'b10, 1,  2'b01, 2'b00, 1'b1, 2'd3};  // FSM reacts next edge
    vecs[12] = '{2'b10, 9,  2'b01, 2'b00, 1'b1, 2'd3};
    vecs[13] = '{2'b11, 10, 2'b00, 2'b00, 1'b1, 2'd3};  // debounced release
    vecs[14] = '{2'b11, 1,  2'b00, 2'b00, 1'b1, 2'd1};  // back to HOLD
    vecs[15] = '{2'b11, 3,  2'b00, 2'b00, 1'b1, 2'd1};
    vecs[16] = '{2'b11, 1,  2'b00, 2'b00, 1'b0, 2'd2};  // full hold restarted

    rst_n  = 1'b0;
    key_in = 2'b11;
    key2   = 2'b11;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    check("reset_level", key_level, 2'b00);
    check("reset_press", key_press, 2'b00);
    check("reset_sys", sys_reset, 1'b1);
    check("reset_state", rst_state, 2'd0);
    check("reset_sys2", sys2, 1'b1);
    rst_n = 1'b1;

    for (int v = 0; v < 17; v++) begin
      key_in = vecs[v].keys;
      repeat (vecs[v].cycles) tick();
      check($sformatf("vec%0d_level", v), key_level, vecs[v].level);
      check($sformatf("vec%0d_press", v), key_press, vecs[v].press);
      check($sformatf("vec%0d_sys", v), sys_reset, vecs[v].sys);
      check($sformatf("vec%0d_state", v), rst_state, vecs[v].state);
    end

    for (int seg = 0; seg < 150; seg++) begin
      key_in = 2'($urandom_range(0, 3));
      repeat ($urandom_range(1, 14)) tick();
    end

    // Async reset pulse between edges: outputs must return at once, no clock needed.
    key_in = 2'b11;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_level", key_level, 2'b00);
    check("async_press", key_press, 2'b00);
    check("async_sys", sys_reset, 1'b1);
    check("async_state", rst_state, 2'd0);
    check("async_sys2", sys2, 1'b1);
    check("async_state2", state2, 2'd0);
    #1 rst_n = 1'b1;
    model_reset();

    // Restart sequence on u_dut; on u_dut2 KEY[0] becomes accepted in the last HOLD cycle.
    for (int c = 1; c <= 9; c++) begin
      if (c == 5) key2 = 2'b10;
      tick();
      if (c == 4) check("restart_sys_held", sys_reset, 1'b1);
      if (c == 5) check("restart_sys_fall", sys_reset, 1'b0);
      if (c == 7) check("prio_state_pre", state2, 2'd1);
      if (c == 8) begin
        check("prio_level_final_hold", level2, 2'b01);
        check("prio_state_final_hold", state2, 2'd1);
        check("prio_sys_final_hold", sys2, 1'b1);
      end
      if (c == 9) begin
        check("prio_state_wait_rel", state2, 2'd3);
        check("prio_sys_wait_rel", sys2, 1'b1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
